// File: rtl/reg_write_arbiter_pkg.sv
// Shared constants for the accumulator processor write-back stage:
// register and source indices, reset values and default widths.
package reg_write_arbiter_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_FLAG_W = 3;
  localparam int DEF_NUM_REGS = 5;
  localparam int DEF_NUM_SRC = 4;
  localparam int DEF_STARVE_LIMIT = 4;

  localparam int ACC_IDX = 0;
  localparam int X_IDX = 1;
  localparam int Y_IDX = 2;
  localparam int SP_IDX = 3;
  localparam int SR_IDX = 4;

  localparam int SP_RESET = 9497;

  localparam int SRC_ALU = 0;
  localparam int SRC_MEM = 1;
  localparam int SRC_XFER = 2;
  localparam int SRC_INPUT = 3;

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Write-request bus shared by all write sources: per-source valid, dest and
// data from the sources, one-hot ready back from the arbiter.
interface reg_write_arbiter_if #(
  parameter int NUM_SRC = 4,
  parameter int IDX_W   = 3,
  parameter int DATA_W  = 32
);

  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC-1:0]        src_ready;
  logic [NUM_SRC*IDX_W-1:0]  src_dest;
  logic [NUM_SRC*DATA_W-1:0] src_data;

  modport master (
    output src_valid,
    output src_dest,
    output src_data,
    input  src_ready
  );

  modport slave (
    input  src_valid,
    input  src_dest,
    input  src_data,
    output src_ready
  );

endinterface

// File: rtl/reg_write_arbiter_arb.sv
// Fixed-priority arbiter with per-source starvation counters; a source that
// has waited STARVE_LIMIT cycles jumps ahead of all unsaturated sources.
module starve_prio_arbiter #(
  parameter int NUM_SRC      = 4,
  parameter int STARVE_LIMIT = 4,
  parameter int SRC_W        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] valid_i,
  output logic [NUM_SRC-1:0] grant_o,
  output logic [SRC_W-1:0]   grant_idx_o,
  output logic               grant_any_o
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0]   cnt_q [NUM_SRC];
  logic [CNT_W-1:0]   cnt_d [NUM_SRC];
  logic [NUM_SRC-1:0] starved;
  logic [NUM_SRC-1:0] candidates;

  // Saturated requesters form the candidate set when any exist; the
  // descending scan leaves the lowest-indexed candidate as the winner.
  always_comb begin
    starved     = '0;
    grant_o     = '0;
    grant_idx_o = '0;
    grant_any_o = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      starved[i] = valid_i[i] && (cnt_q[i] == CNT_MAX);
    end
    candidates = (|starved) ? starved : valid_i;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (candidates[i]) begin
        grant_o     = '0;
        grant_o[i]  = 1'b1;
        grant_idx_o = SRC_W'(i);
        grant_any_o = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      cnt_d[i] = cnt_q[i];
      if (!valid_i[i] || grant_o[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] != CNT_MAX) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Register-file write-back stage: arbitrates one write per cycle among the
// sources, owns the architectural registers and reports each commit.
module reg_write_arbiter #(
  parameter int DATA_W       = reg_write_arbiter_pkg::DEF_DATA_W,
  parameter int NUM_REGS     = reg_write_arbiter_pkg::DEF_NUM_REGS,
  parameter int IDX_W        = $clog2(NUM_REGS),
  parameter int NUM_SRC      = reg_write_arbiter_pkg::DEF_NUM_SRC,
  parameter int FLAG_W       = reg_write_arbiter_pkg::DEF_FLAG_W,
  parameter int SP_IDX       = reg_write_arbiter_pkg::SP_IDX,
  parameter int SR_IDX       = reg_write_arbiter_pkg::SR_IDX,
  parameter int SP_RESET     = reg_write_arbiter_pkg::SP_RESET,
  parameter int STARVE_LIMIT = reg_write_arbiter_pkg::DEF_STARVE_LIMIT
) (
  input  logic                       clock,
  input  logic                       reset,
  reg_write_arbiter_if.slave         wr,
  input  logic                       flag_we,
  input  logic [FLAG_W-1:0]          flag_in,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic [DATA_W-1:0]          status,
  output logic                       commit_valid,
  output logic [IDX_W-1:0]           commit_dest,
  output logic [$clog2(NUM_SRC)-1:0] commit_src
);

  import reg_write_arbiter_pkg::*;

  localparam int SRC_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0] grant;
  logic [SRC_W-1:0]   grant_idx;
  logic               grant_any;

  logic [IDX_W-1:0]   sel_dest;
  logic [DATA_W-1:0]  sel_data;

  logic [DATA_W-1:0]  regs_q [NUM_REGS];
  logic [DATA_W-1:0]  regs_d [NUM_REGS];
  logic               commit_valid_q;
  logic [IDX_W-1:0]   commit_dest_q;
  logic [SRC_W-1:0]   commit_src_q;

  starve_prio_arbiter #(
    .NUM_SRC      (NUM_SRC),
    .STARVE_LIMIT (STARVE_LIMIT),
    .SRC_W        (SRC_W)
  ) u_arb (
    .clock       (clock),
    .reset       (reset),
    .valid_i     (wr.src_valid),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .grant_any_o (grant_any)
  );

  assign wr.src_ready = grant;

  // Data and dest feed only the register update, never the grant.
  always_comb begin
    sel_dest = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant[i]) begin
        sel_dest = wr.src_dest[i*IDX_W +: IDX_W];
        sel_data = wr.src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // The full write is applied after the flag update so it wins a collision;
  // an out-of-range dest matches no register and changes nothing.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      regs_d[r] = regs_q[r];
    end
    if (flag_we) begin
      regs_d[SR_IDX][FLAG_W-1:0] = flag_in;
    end
    for (int r = 0; r < NUM_REGS; r++) begin
      if (grant_any && (sel_dest == IDX_W'(r))) begin
        regs_d[r] = sel_data;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= (r == SP_IDX) ? DATA_W'(SP_RESET) : '0;
      end
      commit_valid_q <= 1'b0;
      commit_dest_q  <= '0;
      commit_src_q   <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= regs_d[r];
      end
      commit_valid_q <= grant_any;
      if (grant_any) begin
        commit_dest_q <= sel_dest;
        commit_src_q  <= grant_idx;
      end
    end
  end

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_flat
    assign regs_flat[r*DATA_W +: DATA_W] = regs_q[r];
  end

  assign status       = regs_q[SR_IDX];
  assign commit_valid = commit_valid_q;
  assign commit_dest  = commit_dest_q;
  assign commit_src   = commit_src_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed scenarios with literal expectations,
// then random traffic checked every cycle against a behavioural model.
module tb_reg_write_arbiter;

  localparam int DATA_W       = 32;
  localparam int NUM_REGS     = 5;
  localparam int IDX_W        = 3;
  localparam int NUM_SRC      = 4;
  localparam int SRC_W        = 2;
  localparam int FLAG_W       = 3;
  localparam int SP_IDX       = 3;
  localparam int SR_IDX       = 4;
  localparam int SP_RESET     = 9497;
  localparam int STARVE_LIMIT = 4;

  logic                       clock = 1'b0;
  logic                       reset = 1'b0;
  logic                       flag_we = 1'b0;
  logic [FLAG_W-1:0]          flag_in = '0;
  logic [NUM_REGS*DATA_W-1:0] regs_flat;
  logic [DATA_W-1:0]          status;
  logic                       commit_valid;
  logic [IDX_W-1:0]           commit_dest;
  logic [SRC_W-1:0]           commit_src;

  reg_write_arbiter_if #(.NUM_SRC(NUM_SRC), .IDX_W(IDX_W), .DATA_W(DATA_W)) wr ();

  reg_write_arbiter #(
    .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .IDX_W(IDX_W), .NUM_SRC(NUM_SRC),
    .FLAG_W(FLAG_W), .SP_IDX(SP_IDX), .SR_IDX(SR_IDX), .SP_RESET(SP_RESET),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .wr           (wr),
    .flag_we      (flag_we),
    .flag_in      (flag_in),
    .regs_flat    (regs_flat),
    .status       (status),
    .commit_valid (commit_valid),
    .commit_dest  (commit_dest),
    .commit_src   (commit_src)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  bit chkOn = 1'b0;

  // Behavioural model: wait counts per source, register contents, last commit.
  int          mWait [NUM_SRC];
  logic [31:0] mRegs [NUM_REGS];
  bit          mCommitValid;
  int          mCommitDest;
  int          mCommitSrc;
  int          mLastAcc = -1;
  int          mG;
  int          cg;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] regAt(input int r);
    return regs_flat[r*DATA_W +: DATA_W];
  endfunction

  function automatic int modelGrant();
    int g = -1;
    for (int i = 0; i < NUM_SRC; i++)
      if (g < 0 && wr.src_valid[i] && mWait[i] >= STARVE_LIMIT) g = i;
    for (int i = 0; i < NUM_SRC; i++)
      if (g < 0 && wr.src_valid[i]) g = i;
    return g;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SRC; i++) mWait[i] = 0;
      for (int r = 0; r < NUM_REGS; r++) mRegs[r] = (r == SP_IDX) ? 32'(SP_RESET) : 32'd0;
      mCommitValid = 1'b0;
      mCommitDest  = 0;
      mCommitSrc   = 0;
      mLastAcc     = -1;
    end else begin
      mG = modelGrant();
      for (int i = 0; i < NUM_SRC; i++) begin
        if (!wr.src_valid[i] || i == mG) mWait[i] = 0;
        else if (mWait[i] < STARVE_LIMIT) mWait[i]++;
      end
      if (flag_we) mRegs[SR_IDX][FLAG_W-1:0] = flag_in;
      mCommitValid = (mG >= 0);
      if (mG >= 0) begin
        mCommitDest = int'(wr.src_dest[mG*IDX_W +: IDX_W]);
        mCommitSrc  = mG;
        if (mCommitDest < NUM_REGS) mRegs[mCommitDest] = wr.src_data[mG*DATA_W +: DATA_W];
      end
      mLastAcc = mG;
    end
  end

  always @(negedge clock) begin
    if (chkOn) begin
      cg = modelGrant();
      checkOutput("ready", 64'(wr.src_ready), (cg >= 0) ? (64'd1 << cg) : 64'd0);
      for (int r = 0; r < NUM_REGS; r++)
        checkOutput($sformatf("reg%0d", r), 64'(regAt(r)), 64'(mRegs[r]));
      checkOutput("status", 64'(status), 64'(mRegs[SR_IDX]));
      checkOutput("commit_valid", 64'(commit_valid), 64'(mCommitValid));
      if (mCommitValid) begin
        checkOutput("commit_dest", 64'(commit_dest), 64'(mCommitDest));
        checkOutput("commit_src", 64'(commit_src), 64'(mCommitSrc));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic setSrc(input int i, input int dest, input logic [31:0] data);
    wr.src_dest[i*IDX_W +: IDX_W]   = IDX_W'(dest);
    wr.src_data[i*DATA_W +: DATA_W] = data;
  endtask

  task automatic applyStimulus(input logic [NUM_SRC-1:0] v, input logic fwe, input logic [FLAG_W-1:0] fin);
    wr.src_valid = v;
    flag_we      = fwe;
    flag_in      = fin;
  endtask

  initial begin
    wr.src_valid = '0;
    wr.src_dest  = '0;
    wr.src_data  = '0;
    #2 reset = 1'b1;
    chkOn = 1'b1;
    #1;
    checkOutput("rst_sp", 64'(regAt(SP_IDX)), 64'd9497);
    checkOutput("rst_acc", 64'(regAt(0)), 64'd0);
    checkOutput("rst_sr", 64'(status), 64'd0);
    checkOutput("rst_cv", 64'(commit_valid), 64'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Single write from source 1 to X.
    setSrc(1, 1, 32'h0000_00AB);
    applyStimulus(4'b0010, 1'b0, '0);
    #1 checkOutput("single_ready", 64'(wr.src_ready), 64'b0010);
    tick();
    applyStimulus(4'b0000, 1'b0, '0);
    #1;
    checkOutput("single_x", 64'(regAt(1)), 64'hAB);
    checkOutput("single_cv", 64'(commit_valid), 64'd1);
    checkOutput("single_cdest", 64'(commit_dest), 64'd1);
    checkOutput("single_csrc", 64'(commit_src), 64'd1);
    tick();
    #1 checkOutput("single_cv_drop", 64'(commit_valid), 64'd0);

    // Static priority: source 0 before source 2.
    setSrc(0, 0, 32'd5);
    setSrc(2, 2, 32'd7);
    applyStimulus(4'b0101, 1'b0, '0);
    #1 checkOutput("prio_ready0", 64'(wr.src_ready), 64'b0001);
    tick();
    applyStimulus(4'b0100, 1'b0, '0);
    #1;
    checkOutput("prio_acc", 64'(regAt(0)), 64'd5);
    checkOutput("prio_y_before", 64'(regAt(2)), 64'd0);
    checkOutput("prio_ready2", 64'(wr.src_ready), 64'b0100);
    tick();
    applyStimulus(4'b0000, 1'b0, '0);
    #1;
    checkOutput("prio_y", 64'(regAt(2)), 64'd7);
    checkOutput("prio_csrc", 64'(commit_src), 64'd2);

    // Starvation: source 3 wins on its fifth waiting cycle.
    setSrc(3, 1, 32'h33);
    for (int k = 1; k <= 5; k++) begin
      setSrc(0, 0, 32'h100 + 32'(k));
      applyStimulus(4'b1001, 1'b0, '0);
      #1 checkOutput($sformatf("starve_ready%0d", k), 64'(wr.src_ready), (k == 5) ? 64'b1000 : 64'b0001);
      tick();
    end
    setSrc(0, 0, 32'h106);
    applyStimulus(4'b0001, 1'b0, '0);
    #1;
    checkOutput("starve_resume", 64'(wr.src_ready), 64'b0001);
    checkOutput("starve_x", 64'(regAt(1)), 64'h33);
    checkOutput("starve_csrc", 64'(commit_src), 64'd3);
    tick();
    applyStimulus(4'b0000, 1'b0, '0);
    #1 checkOutput("starve_acc", 64'(regAt(0)), 64'h106);

    // Flag path alone, then colliding with a full SR write.
    applyStimulus(4'b0000, 1'b1, 3'b101);
    tick();
    applyStimulus(4'b0000, 1'b0, '0);
    #1 checkOutput("flag_only", 64'(status), 64'h5);
    setSrc(0, SR_IDX, 32'hFFFF_0000);
    applyStimulus(4'b0001, 1'b1, 3'b010);
    tick();
    applyStimulus(4'b0000, 1'b0, '0);
    #1 checkOutput("flag_collide", 64'(status), 64'hFFFF_0000);

    // Out-of-range destination: committed, no register changes.
    setSrc(2, 7, 32'hDEAD_BEEF);
    applyStimulus(4'b0100, 1'b0, '0);
    tick();
    applyStimulus(4'b0000, 1'b0, '0);
    #1;
    checkOutput("oor_cv", 64'(commit_valid), 64'd1);
    checkOutput("oor_cdest", 64'(commit_dest), 64'd7);
    checkOutput("oor_csrc", 64'(commit_src), 64'd2);
    checkOutput("oor_acc", 64'(regAt(0)), 64'h106);
    checkOutput("oor_x", 64'(regAt(1)), 64'h33);
    checkOutput("oor_y", 64'(regAt(2)), 64'd7);
    checkOutput("oor_sp", 64'(regAt(SP_IDX)), 64'd9497);
    checkOutput("oor_sr", 64'(status), 64'hFFFF_0000);

    // Asynchronous reset in the middle of a cycle.
    tick();
    #1 reset = 1'b1;
    #1;
    checkOutput("mid_rst_acc", 64'(regAt(0)), 64'd0);
    checkOutput("mid_rst_x", 64'(regAt(1)), 64'd0);
    checkOutput("mid_rst_sp", 64'(regAt(SP_IDX)), 64'd9497);
    checkOutput("mid_rst_sr", 64'(status), 64'd0);
    checkOutput("mid_rst_cv", 64'(commit_valid), 64'd0);
    tick();
    reset = 1'b0;

    // Random traffic; pending requests stay stable until accepted or withdrawn.
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int i = 0; i < NUM_SRC; i++) begin
        if (!wr.src_valid[i] || mLastAcc == i) begin
          if ($urandom_range(99) < 55) begin
            wr.src_valid[i] = 1'b1;
            setSrc(i, int'($urandom_range(7)), $urandom);
          end else begin
            wr.src_valid[i] = 1'b0;
          end
        end else if ($urandom_range(99) < 4) begin
          wr.src_valid[i] = 1'b0;
        end
      end
      flag_we = ($urandom_range(99) < 15);
      flag_in = FLAG_W'($urandom_range(7));
      if (c == 1500) begin
        #1 reset = 1'b1;
        tick();
        reset = 1'b0;
      end
    end

    tick();
    applyStimulus(4'b0000, 1'b0, '0);
    repeat (2) tick();
    chkOn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Parametrised register-file write-back stage for the accumulator processor. It replaces the hard-coded per-opcode write decoding with a valid/ready arbiter: NUM_SRC write sources (ALU, memory, input port, register transfer, …) compete for one register-file write per cycle. Arbitration is fixed-priority with per-source starvation promotion. The block owns the architectural registers (Acc, X, Y, SP, SR, …), a dedicated status-flag update path, and a registered commit report for the control unit.

## Interface
Parameters:
- DATA_W, 32, register width
- NUM_REGS, 5, number of architectural registers
- IDX_W, $clog2(NUM_REGS), destination index width
- NUM_SRC, 4, number of write sources; index 0 has highest static priority
- FLAG_W, 3, status-flag field width (SR bits [FLAG_W-1:0])
- SP_IDX, 3, stack-pointer register index
- SR_IDX, 4, status-register index
- SP_RESET, 9497, SP reset value
- STARVE_LIMIT, 4, wait cycles before a source is promoted

Ports (one clock; reset is asynchronous and active-high):
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- src_valid  in  NUM_SRC  per-source write request
- src_ready  out  NUM_SRC  per-source grant, combinational, one-hot or zero
- src_dest  in  NUM_SRC*IDX_W  per-source destination index, packed
- src_data  in  NUM_SRC*DATA_W  per-source write data, packed
- flag_we  in  1  update SR flag field
- flag_in  in  FLAG_W  new flag value
- regs_flat  out  NUM_REGS*DATA_W  all registers; reg i at [i*DATA_W +: DATA_W]
- status  out  DATA_W  copy of register SR_IDX
- commit_valid  out  1  registered; pulses the cycle after an accepted write
- commit_dest  out  IDX_W  destination of that write
- commit_src  out  $clog2(NUM_SRC)  source index of that write

## Operation
- Reset: all registers 0, except SP_IDX = SP_RESET. All starvation counters 0. commit_valid = 0, commit_dest = 0, commit_src = 0.
- Handshake: a write is accepted at a clock edge when src_valid[i] && src_ready[i]. A source keeps valid, dest and data stable until accepted. Withdrawing valid before acceptance is legal and clears that source's counter.
- Grant: at most one src_ready bit is high per cycle.
  - If any valid source has counter == STARVE_LIMIT, the lowest-indexed such source wins.
  - Otherwise the lowest-indexed valid source wins.
  - src_ready depends only on src_valid and registered counters; there is no combinational path from src_data or src_dest.
- Starvation counter, per source:
  - Increments when valid && !ready.
  - Saturates at STARVE_LIMIT.
  - Clears on accept or when valid is low.
- Destination out of range (>= NUM_REGS): the request is still accepted and the commit is reported, but no register changes.
- Flag path: when flag_we is high, SR[FLAG_W-1:0] <= flag_in and the upper SR bits are unchanged.
- Collision: a granted full write to SR_IDX in the same cycle as flag_we wins, and flag_in is dropped.
- Writes to SP_IDX have no special behaviour beyond the reset value.

## Timing
- Accept at edge N means the new value appears on regs_flat/status after edge N.
- commit_valid/dest/src are high during cycle N+1 only, unless another accept occurs at edge N+1.
- Worst-case wait for any continuously valid source is bounded. Once its counter saturates, only lower-indexed saturated sources can precede it.
- Reset asserted mid-operation clears all state immediately. Requests pending at deassertion are re-arbitrated from zero counters.

## Structure
- Shared package (e.g. acc_proc_pkg) holds:
  - Register index constants: ACC_IDX = 0, X_IDX = 1, Y_IDX = 2, SP_IDX = 3, SR_IDX = 4.
  - SP_RESET and the default DATA_W / FLAG_W.
  - Source index constants: SRC_ALU = 0, SRC_MEM = 1, SRC_XFER = 2, SRC_INPUT = 3.
- One sub-module, starve_prio_arbiter, holds the counters and grant logic. It is parametrised on NUM_SRC and STARVE_LIMIT.

## Test plan
- Reset: drive reset high asynchronously mid-cycle -> regs_flat reads 0 everywhere except SP = 9497, SR = 0, commit_valid = 0, and this holds before the next clock edge.
- Single write: src 1 valid, dest = X_IDX, data = 0x0000_00AB -> src_ready = 0b0010; X = 0xAB on the next cycle; commit_valid = 1 with dest 1, src 1 for exactly one cycle.
- Priority: srcs 0 and 2 valid in the same cycle, writing Acc = 5 and Y = 7 -> src 0 granted first; src 2 is granted the following cycle; Acc = 5 then Y = 7, one cycle apart.
- Starvation: src 0 valid continuously with changing data and src 3 valid, STARVE_LIMIT = 4 -> src 3 is granted on the 5th cycle of waiting, and src 0 resumes afterwards.
- Flag collision: flag_we = 1 with flag_in = 3'b101 only -> SR = 0x5. Then flag_we with flag_in = 3'b010 plus a granted write SR = 0xFFFF_0000 in the same cycle -> SR = 0xFFFF_0000.
- Out-of-range: dest = 7 with NUM_REGS = 5 -> accepted, commit_valid = 1 with dest 7, and every register is unchanged.
